// File: rtl/lpif_phy_endpoint.sv
// lpif_phy_endpoint: PHY-side LPIF endpoint.
// It terminates the link-layer transmit stream into a DEPTH-entry FIFO that
// feeds the logical PHY. It also runs the LPIF link-state machine, which covers
// the L1 stall handshake, L1 exit, retrain and link reset.
// Optional feature: define LPIF_CG_EN to add the ex_cg_req/ex_cg_ack clock-gate
// exit handshake.
module lpif_phy_endpoint #(
    parameter int NBYTES         = 4,
    parameter int PL_NVLD        = 1,
    parameter int DEPTH          = 4,
    parameter int RETRAIN_CYCLES = 16,
    parameter int L1_EXIT_CYCLES = 8
) (
    input  logic                  PCLK,
    input  logic                  reset,
    input  logic [NBYTES*8-1:0]   lp_data,
    input  logic [PL_NVLD-1:0]    lp_valid,
    input  logic                  lp_irdy,
    output logic                  pl_trdy,
    input  logic [3:0]            state_req,
    output logic [3:0]            state_sts,
    output logic                  stall_req,
    input  logic                  stall_ack,
    input  logic                  phy_ready,
    input  logic                  phy_retrain,
    output logic                  link_up,
    output logic                  phyinl1,
    output logic                  phyinrecenter,
    output logic [NBYTES*8-1:0]   tx_data,
    output logic [PL_NVLD-1:0]    tx_valid_bits,
    output logic                  tx_vld,
    input  logic                  tx_ready
`ifdef LPIF_CG_EN
    ,
    input  logic                  ex_cg_req,
    output logic                  ex_cg_ack
`endif
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW      = NBYTES * 8;
    localparam int EW      = DW + PL_NVLD;
    localparam int CNT_MAX = (RETRAIN_CYCLES > L1_EXIT_CYCLES) ? RETRAIN_CYCLES : L1_EXIT_CYCLES;
    localparam int CW      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CW-1:0] RT_LOAD    = CW'(RETRAIN_CYCLES - 1);
    localparam logic [CW-1:0] EX_LOAD    = CW'(L1_EXIT_CYCLES - 1);
    localparam logic [AW:0]   FIFO_DEPTH = (AW + 1)'(DEPTH);

    localparam logic [3:0] REQ_NOP    = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE = 4'b0001;
    localparam logic [3:0] REQ_L1     = 4'b0100;
    localparam logic [3:0] REQ_LRST   = 4'b1001;

    localparam logic [3:0] STS_RESET   = 4'b0000;
    localparam logic [3:0] STS_ACTIVE  = 4'b0001;
    localparam logic [3:0] STS_L1      = 4'b0100;
    localparam logic [3:0] STS_RETRAIN = 4'b1011;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_ACTIVE  = 3'd1,
        ST_STALL   = 3'd2,
        ST_L1      = 3'd3,
        ST_EXIT    = 3'd4,
        ST_RETRAIN = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;

    logic link_reset;
    logic push;
    logic pop;
    logic cg_wake;

    // A link-reset request takes priority in every state and also flushes the FIFO.
    assign link_reset = (state_req == REQ_LRST);
    assign push       = lp_irdy && pl_trdy;
    assign pop        = tx_vld && tx_ready;

`ifdef LPIF_CG_EN
    assign cg_wake = ex_cg_req;
`else
    assign cg_wake = 1'b0;
`endif

    // State register, together with the shared EXIT/RETRAIN down-counter.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic. Requests that are not listed for a state are ignored.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (link_reset) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (state_req == REQ_ACTIVE && phy_ready) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (phy_retrain) begin
                        state_d = ST_RETRAIN;
                        timer_d = RT_LOAD;
                    end else if (state_req == REQ_L1) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    // L1 is entered only once the link layer has acked and every queued beat has left.
                    if (stall_ack && count_q == '0) begin
                        state_d = ST_L1;
                    end
                end
                ST_L1: begin
                    if (state_req == REQ_ACTIVE || cg_wake) begin
                        state_d = ST_EXIT;
                        timer_d = EX_LOAD;
                    end
                end
                ST_EXIT, ST_RETRAIN: begin
                    if (timer_q == '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // Status outputs, decoded from the state register.
    always_comb begin
        state_sts     = STS_RESET;
        link_up       = 1'b0;
        phyinl1       = 1'b0;
        phyinrecenter = 1'b0;
        stall_req     = 1'b0;
        pl_trdy       = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                state_sts = STS_ACTIVE;
                link_up   = 1'b1;
                // Full means not ready, even if a pop happens in the same cycle.
                pl_trdy   = (count_q < FIFO_DEPTH);
            end
            ST_STALL: begin
                state_sts = STS_ACTIVE;
                link_up   = 1'b1;
                stall_req = 1'b1;
            end
            ST_L1: begin
                state_sts = STS_L1;
                phyinl1   = 1'b1;
            end
            ST_EXIT, ST_RETRAIN: begin
                state_sts     = STS_RETRAIN;
                link_up       = 1'b1;
                phyinrecenter = 1'b1;
            end
            default: begin
                state_sts = STS_RESET;
            end
        endcase
    end

    // FIFO pointers and occupancy. A link reset flushes everything that is queued.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (link_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage. Each entry holds the data and its valid bits; the storage itself needs no reset.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lp_valid, lp_data};
        end
    end

    // The head entry appears on tx_* in the cycle after the push. The outputs read zero while the FIFO is empty.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        tx_vld        = (count_q != '0);
        tx_data       = tx_vld ? head[DW-1:0] : '0;
        tx_valid_bits = tx_vld ? head[EW-1:DW] : '0;
    end

`ifdef LPIF_CG_EN
    logic ex_cg_ack_q;

    // Clock-gate acknowledge. It is granted directly in RESET or ACTIVE.
    // When the request woke the link from L1, the grant waits for EXIT to return to ACTIVE.
    // The acknowledge drops once the request is withdrawn.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            ex_cg_ack_q <= 1'b0;
        end else if (!ex_cg_req) begin
            ex_cg_ack_q <= 1'b0;
        end else if (state_q == ST_RESET || state_q == ST_ACTIVE) begin
            ex_cg_ack_q <= 1'b1;
        end else if (state_q == ST_EXIT && state_d == ST_ACTIVE) begin
            ex_cg_ack_q <= 1'b1;
        end
    end

    assign ex_cg_ack = ex_cg_ack_q;
`endif

endmodule

// File: tb/tb_lpif_phy_endpoint.sv
// Directed testbench for lpif_phy_endpoint. It runs a table of per-cycle vectors
// and then hand-written sequences for L1 entry, retrain, link reset and
// asynchronous reset. When LPIF_CG_EN is defined it also runs the clock-gate exit.
module tb_lpif_phy_endpoint;

    logic        PCLK;
    logic        reset;
    logic [31:0] lp_data;
    logic [0:0]  lp_valid;
    logic        lp_irdy;
    logic        pl_trdy;
    logic [3:0]  state_req;
    logic [3:0]  state_sts;
    logic        stall_req;
    logic        stall_ack;
    logic        phy_ready;
    logic        phy_retrain;
    logic        link_up;
    logic        phyinl1;
    logic        phyinrecenter;
    logic [31:0] tx_data;
    logic [0:0]  tx_valid_bits;
    logic        tx_vld;
    logic        tx_ready;
`ifdef LPIF_CG_EN
    logic        ex_cg_req;
    logic        ex_cg_ack;
`endif

    int passed = 0;
    int total  = 0;

    lpif_phy_endpoint dut (
        .PCLK          (PCLK),
        .reset         (reset),
        .lp_data       (lp_data),
        .lp_valid      (lp_valid),
        .lp_irdy       (lp_irdy),
        .pl_trdy       (pl_trdy),
        .state_req     (state_req),
        .state_sts     (state_sts),
        .stall_req     (stall_req),
        .stall_ack     (stall_ack),
        .phy_ready     (phy_ready),
        .phy_retrain   (phy_retrain),
        .link_up       (link_up),
        .phyinl1       (phyinl1),
        .phyinrecenter (phyinrecenter),
        .tx_data       (tx_data),
        .tx_valid_bits (tx_valid_bits),
        .tx_vld        (tx_vld),
        .tx_ready      (tx_ready)
`ifdef LPIF_CG_EN
        ,
        .ex_cg_req     (ex_cg_req),
        .ex_cg_ack     (ex_cg_ack)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        rt;
        logic        irdy;
        logic [31:0] data;
        logic        txr;
        logic [3:0]  e_sts;
        logic        e_link;
        logic        e_trdy;
        logic        e_vld;
        logic [31:0] e_txd;
    } vec_t;

    vec_t vecs [18];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        logic bad;

        // Table: inputs for one cycle, then the outputs expected after that cycle's edge.
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{4'h1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA0};
        vecs[5]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA0};
        vecs[6]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA0};
        vecs[7]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 32'hA0};
        vecs[8]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA4, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 32'hA0};
        vecs[9]  = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA4, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA1};
        vecs[10] = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hA4, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA2};
        vecs[11] = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA3};
        vecs[12] = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 32'hA4};
        vecs[13] = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hB5, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 32'hB5};
        vecs[15] = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{4'h2, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{4'h1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 32'h0};

        reset       = 1'b1;
        lp_data     = '0;
        lp_valid    = 1'b1;
        lp_irdy     = 1'b0;
        state_req   = 4'h0;
        stall_ack   = 1'b0;
        phy_ready   = 1'b0;
        phy_retrain = 1'b0;
        tx_ready    = 1'b0;
`ifdef LPIF_CG_EN
        ex_cg_req   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_sts", 32'(state_sts), 32'h0);
        chk("rst_trdy", 32'(pl_trdy), 32'h0);
        chk("rst_stall", 32'(stall_req), 32'h0);
        chk("rst_flags", 32'({link_up, phyinl1, phyinrecenter}), 32'h0);
        chk("rst_txvld", 32'(tx_vld), 32'h0);
        chk("rst_txdata", tx_data, 32'h0);
        chk("rst_txvb", 32'(tx_valid_bits), 32'h0);
`ifdef LPIF_CG_EN
        chk("rst_cgack", 32'(ex_cg_ack), 32'h0);
`endif
        reset = 1'b0;

        // Bring-up, backpressure and ordering, empty-push/next-pop, and ignored requests.
        for (int i = 0; i < 18; i++) begin
            state_req   = vecs[i].req;
            phy_ready   = vecs[i].rdy;
            phy_retrain = vecs[i].rt;
            lp_irdy     = vecs[i].irdy;
            lp_data     = vecs[i].data;
            tx_ready    = vecs[i].txr;
            tick();
            $display("vec %0d: sts=%0h link=%0b trdy=%0b vld=%0b txd=%0h", i, state_sts, link_up, pl_trdy, tx_vld, tx_data);
            chk($sformatf("v%0d_sts", i), 32'(state_sts), 32'(vecs[i].e_sts));
            chk($sformatf("v%0d_link", i), 32'(link_up), 32'(vecs[i].e_link));
            chk($sformatf("v%0d_trdy", i), 32'(pl_trdy), 32'(vecs[i].e_trdy));
            chk($sformatf("v%0d_vld", i), 32'(tx_vld), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_txd", i), tx_data, vecs[i].e_txd);
        end
        chk("valid_bits", 32'(tx_valid_bits), 32'h0);

        // L1 entry with two beats queued, then L1 exit.
        state_req = 4'h0; tx_ready = 1'b0; lp_irdy = 1'b1;
        lp_data = 32'hC0; tick();
        lp_data = 32'hC1; tick();
        lp_irdy = 1'b0; state_req = 4'h4; stall_ack = 1'b1;
        tick();
        $display("l1: stall entered sts=%0h stall_req=%0b", state_sts, stall_req);
        chk("stall_sts", 32'(state_sts), 32'h1);
        chk("stall_req", 32'(stall_req), 32'h1);
        chk("stall_trdy", 32'(pl_trdy), 32'h0);
        tick();
        chk("stall_hold", 32'(stall_req), 32'h1);
        chk("stall_head", tx_data, 32'hC0);
        tx_ready = 1'b1; tick();
        chk("stall_drain1", tx_data, 32'hC1);
        chk("stall_drain1_req", 32'(stall_req), 32'h1);
        tick();
        chk("stall_empty_vld", 32'(tx_vld), 32'h0);
        chk("stall_empty_req", 32'(stall_req), 32'h1);
        tick();
        $display("l1: sts=%0h phyinl1=%0b", state_sts, phyinl1);
        chk("l1_sts", 32'(state_sts), 32'h4);
        chk("l1_flag", 32'(phyinl1), 32'h1);
        chk("l1_stall", 32'(stall_req), 32'h0);
        chk("l1_link", 32'(link_up), 32'h0);
        tick();
        chk("l1_ignore_req", 32'(state_sts), 32'h4);
        state_req = 4'h1; tick();
        state_req = 4'h0; stall_ack = 1'b0; tx_ready = 1'b0;
        n = 0; guard = 0; bad = 1'b0;
        while (state_sts == 4'b1011 && guard < 40) begin
            n++;
            if (phyinrecenter !== 1'b1) bad = 1'b1;
            tick();
            guard++;
        end
        $display("l1 exit: %0d cycles in 1011, then sts=%0h", n, state_sts);
        chk("exit_cycles", 32'(n), 32'd8);
        chk("exit_recenter", 32'(bad), 32'h0);
        chk("exit_done_sts", 32'(state_sts), 32'h1);

        // Retrain: pl_trdy must stay low the whole time the link layer is offering a beat.
        phy_retrain = 1'b1; tick();
        phy_retrain = 1'b0; lp_irdy = 1'b1; lp_data = 32'hD0;
        n = 0; guard = 0; bad = 1'b0;
        while (state_sts == 4'b1011 && guard < 40) begin
            n++;
            if (pl_trdy !== 1'b0 || phyinrecenter !== 1'b1) bad = 1'b1;
            tick();
            guard++;
        end
        lp_irdy = 1'b0;
        $display("retrain: %0d cycles, then sts=%0h vld=%0b", n, state_sts, tx_vld);
        chk("retrain_cycles", 32'(n), 32'd16);
        chk("retrain_trdy_low", 32'(bad), 32'h0);
        chk("retrain_done_sts", 32'(state_sts), 32'h1);
        chk("retrain_no_push", 32'(tx_vld), 32'h0);

        // Link reset issued in STALL with three beats queued.
        lp_irdy = 1'b1;
        lp_data = 32'hE0; tick();
        lp_data = 32'hE1; tick();
        lp_data = 32'hE2; tick();
        lp_irdy = 1'b0; state_req = 4'h4; stall_ack = 1'b0; tick();
        chk("lr_in_stall", 32'(stall_req), 32'h1);
        chk("lr_queued", 32'(tx_vld), 32'h1);
        state_req = 4'h9; tick();
        $display("linkreset: sts=%0h vld=%0b stall_req=%0b", state_sts, tx_vld, stall_req);
        chk("lr_sts", 32'(state_sts), 32'h0);
        chk("lr_vld", 32'(tx_vld), 32'h0);
        chk("lr_stall", 32'(stall_req), 32'h0);
        chk("lr_trdy", 32'(pl_trdy), 32'h0);
        state_req = 4'h0; tick();
        chk("lr_stay", 32'(state_sts), 32'h0);
        state_req = 4'h1; tick();
        state_req = 4'h0;
        chk("lr_rebring", 32'(state_sts), 32'h1);
        chk("lr_flushed", 32'(tx_vld), 32'h0);

`ifdef LPIF_CG_EN
        // Clock-gate request in L1 wakes the link. The ack comes with the return to ACTIVE.
        state_req = 4'h4; stall_ack = 1'b1; tick();
        tick();
        chk("cg_l1", 32'(state_sts), 32'h4);
        state_req = 4'h0; stall_ack = 1'b0; ex_cg_req = 1'b1; tick();
        chk("cg_exit", 32'(state_sts), 32'hB);
        n = 0; guard = 0; bad = 1'b0;
        while (state_sts == 4'b1011 && guard < 40) begin
            n++;
            if (ex_cg_ack !== 1'b0) bad = 1'b1;
            tick();
            guard++;
        end
        $display("cg: exit %0d cycles, sts=%0h ack=%0b", n, state_sts, ex_cg_ack);
        chk("cg_exit_cycles", 32'(n), 32'd8);
        chk("cg_ack_early", 32'(bad), 32'h0);
        chk("cg_ack_sts", 32'(state_sts), 32'h1);
        chk("cg_ack", 32'(ex_cg_ack), 32'h1);
        ex_cg_req = 1'b0; tick();
        chk("cg_ack_fall", 32'(ex_cg_ack), 32'h0);
`endif

        // Asynchronous reset in the middle of a cycle, with one beat queued.
        lp_irdy = 1'b1; lp_data = 32'hF0; tick();
        lp_irdy = 1'b0;
        chk("ar_pre_vld", 32'(tx_vld), 32'h1);
        #2 reset = 1'b1;
        #1;
        $display("async reset: sts=%0h vld=%0b link=%0b", state_sts, tx_vld, link_up);
        chk("ar_sts", 32'(state_sts), 32'h0);
        chk("ar_vld", 32'(tx_vld), 32'h0);
        chk("ar_link", 32'(link_up), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_stay_reset", 32'(state_sts), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
